// File: rtl/exec_stage_ctrl_if.sv
// exec_stage_ctrl_if
// Handshake and ALU bus for the Y86-64 execute-stage controller.
//   upstream   : in_valid/in_ready, icode, ifun, valA, valB, valC
//   ALU        : alu_a, alu_b, alu_ctrl (to ALU), alu_o, alu_of (from ALU)
//   downstream : out_valid/out_ready, valE, cnd
//   status     : cc_zf, cc_sf, cc_of
// Modports:
//   master : the execute-stage controller (initiator of the ALU operation)
//   slave  : the surrounding pipeline and the combinational ALU
interface exec_stage_ctrl_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [W-1:0] valC;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_ctrl;
    logic [W-1:0] alu_o;
    logic         alu_of;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] valE;
    logic         cnd;
    logic         cc_zf;
    logic         cc_sf;
    logic         cc_of;

    modport master (
        input  in_valid, icode, ifun, valA, valB, valC,
        output in_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_o, alu_of,
        output out_valid,
        input  out_ready,
        output valE, cnd, cc_zf, cc_sf, cc_of
    );

    modport slave (
        output in_valid, icode, ifun, valA, valB, valC,
        input  in_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_o, alu_of,
        input  out_valid,
        output out_ready,
        input  valE, cnd, cc_zf, cc_sf, cc_of
    );
endinterface

// File: rtl/exec_stage_ctrl.sv
// exec_stage_ctrl
// Y86-64 execute-stage controller. Accepts one decoded instruction per
// IDLE->EXEC->DONE pass, drives an external combinational ALU during EXEC,
// registers valE and cnd, and maintains the ZF/SF/OF condition codes.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : exec_stage_ctrl_if.master (handshakes, ALU bus, results, CCs)
// Build option:
//   EXEC_CMOV_EN : when defined, icode 2 (cmovXX) evaluates cnd from ifun
//                  like jXX; otherwise icode 2 always yields cnd=1.
module exec_stage_ctrl #(
    parameter int W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    exec_stage_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] IC_CMOV  = 4'h2;
    localparam logic [3:0] IC_IRMOV = 4'h3;
    localparam logic [3:0] IC_RMMOV = 4'h4;
    localparam logic [3:0] IC_MRMOV = 4'h5;
    localparam logic [3:0] IC_OPQ   = 4'h6;
    localparam logic [3:0] IC_JXX   = 4'h7;
    localparam logic [3:0] IC_CALL  = 4'h8;
    localparam logic [3:0] IC_RET   = 4'h9;
    localparam logic [3:0] IC_PUSH  = 4'hA;
    localparam logic [3:0] IC_POP   = 4'hB;

    state_t       state;
    state_t       state_next;

    logic [3:0]   icode_q;
    logic [3:0]   ifun_q;
    logic [W-1:0] vala_q;
    logic [W-1:0] valb_q;
    logic [W-1:0] valc_q;
    logic [W-1:0] vale_q;
    logic         cnd_q;
    logic         zf_q;
    logic         sf_q;
    logic         of_q;

    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_ctrl;
    logic         cond_val;
    logic         cnd_next;
    logic         cc_update;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: handshakes, and the ALU operand/op selection which is only
    // presented during EXEC so the ALU bus stays quiet otherwise.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = 2'b00;
        case (state)
            IDLE: in_ready = 1'b1;
            EXEC: begin
                case (icode_q)
                    IC_OPQ: begin
                        alu_a    = valb_q;
                        alu_b    = vala_q;
                        alu_ctrl = (ifun_q <= 4'd3) ? ifun_q[1:0] : 2'b00;
                    end
                    IC_CMOV:            alu_a = vala_q;
                    IC_IRMOV:           alu_a = valc_q;
                    IC_RMMOV, IC_MRMOV: begin
                        alu_a = valb_q;
                        alu_b = valc_q;
                    end
                    // Stack push: adding -8 moves the stack pointer down.
                    IC_CALL, IC_PUSH: begin
                        alu_a = valb_q;
                        alu_b = {{(W-4){1'b1}}, 4'h8};
                    end
                    IC_RET, IC_POP: begin
                        alu_a = valb_q;
                        alu_b = W'(8);
                    end
                    default: ;
                endcase
            end
            DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Branch/move condition from the CCs as they stand before this
    // instruction's own update.
    always_comb begin
        cond_val = 1'b0;
        case (ifun_q)
            4'd0:    cond_val = 1'b1;
            4'd1:    cond_val = (sf_q ^ of_q) | zf_q;
            4'd2:    cond_val = sf_q ^ of_q;
            4'd3:    cond_val = zf_q;
            4'd4:    cond_val = ~zf_q;
            4'd5:    cond_val = ~(sf_q ^ of_q);
            4'd6:    cond_val = ~(sf_q ^ of_q) & ~zf_q;
            default: cond_val = 1'b0;
        endcase
    end

    always_comb begin
        cnd_next = 1'b1;
        if (icode_q == IC_JXX) begin
            cnd_next = cond_val;
        end
`ifdef EXEC_CMOV_EN
        if (icode_q == IC_CMOV) begin
            cnd_next = cond_val;
        end
`endif
    end

    // Only genuine OPq functions touch the CCs; undefined ifun acts as add
    // but leaves the flags alone.
    assign cc_update = (icode_q == IC_OPQ) && (ifun_q <= 4'd3);

    // Instruction latch, result registers and condition codes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icode_q <= '0;
            ifun_q  <= '0;
            vala_q  <= '0;
            valb_q  <= '0;
            valc_q  <= '0;
            vale_q  <= '0;
            cnd_q   <= 1'b0;
            zf_q    <= 1'b1;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            if (state == IDLE && bus.in_valid) begin
                icode_q <= bus.icode;
                ifun_q  <= bus.ifun;
                vala_q  <= bus.valA;
                valb_q  <= bus.valB;
                valc_q  <= bus.valC;
            end
            if (state == EXEC) begin
                vale_q <= bus.alu_o;
                cnd_q  <= cnd_next;
                if (cc_update) begin
                    zf_q <= (bus.alu_o == '0);
                    sf_q <= bus.alu_o[W-1];
                    of_q <= bus.alu_of;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.alu_a     = alu_a;
    assign bus.alu_b     = alu_b;
    assign bus.alu_ctrl  = alu_ctrl;
    assign bus.valE      = vale_q;
    assign bus.cnd       = cnd_q;
    assign bus.cc_zf     = zf_q;
    assign bus.cc_sf     = sf_q;
    assign bus.cc_of     = of_q;

endmodule

// File: tb/tb_exec_stage_ctrl.sv
// tb_exec_stage_ctrl
// Self-checking bench for exec_stage_ctrl: reset values, a directed vector
// table (carrying CC state from one entry to the next), backpressure with
// dropped in_valid pulses, reset during EXEC, and randomized instructions
// against a behavioural model. Provides the combinational 64-bit ALU.
// Honors EXEC_CMOV_EN the same way as the design.
module tb_exec_stage_ctrl;

`ifdef EXEC_CMOV_EN
    localparam bit CMOV_EN = 1'b1;
`else
    localparam bit CMOV_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [63:0] valC;
        logic [63:0] aluA;
        logic [63:0] aluB;
        logic [1:0]  aluCtrl;
        logic [63:0] valE;
        logic        cnd;
        logic        zf;
        logic        sf;
        logic        of;
    } vec_t;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;
    logic mZf, mSf, mOf;

    exec_stage_ctrl_if #(.W(64)) bus ();

    exec_stage_ctrl #(.W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        bus.alu_o  = '0;
        bus.alu_of = 1'b0;
        case (bus.alu_ctrl)
            2'b00: begin
                bus.alu_o  = bus.alu_a + bus.alu_b;
                bus.alu_of = (bus.alu_a[63] == bus.alu_b[63]) && (bus.alu_o[63] != bus.alu_a[63]);
            end
            2'b01: begin
                bus.alu_o  = bus.alu_a - bus.alu_b;
                bus.alu_of = (bus.alu_a[63] != bus.alu_b[63]) && (bus.alu_o[63] != bus.alu_a[63]);
            end
            2'b10:   bus.alu_o = bus.alu_a & bus.alu_b;
            default: bus.alu_o = bus.alu_a ^ bus.alu_b;
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn,
                                input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                                input logic [63:0] aa, input logic [63:0] ab, input logic [1:0] ctl,
                                input logic [63:0] e, input logic cd,
                                input logic z, input logic s, input logic o);
        vec_t v;
        v.icode = ic; v.ifun = fn; v.valA = a; v.valB = b; v.valC = c;
        v.aluA = aa; v.aluB = ab; v.aluCtrl = ctl;
        v.valE = e; v.cnd = cd; v.zf = z; v.sf = s; v.of = o;
        return v;
    endfunction

    // Behavioural model: derives the expected transaction from the
    // instruction semantics and advances the model CC state.
    function automatic vec_t refModel(input logic [3:0] ic, input logic [3:0] fn,
                                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        vec_t v;
        logic signed [64:0] wide;
        bit lt;
        bit cond;
        v.icode = ic; v.ifun = fn; v.valA = a; v.valB = b; v.valC = c;
        v.aluA = 64'd0; v.aluB = 64'd0; v.aluCtrl = 2'b00; v.cnd = 1'b1;
        lt = mSf ^ mOf;
        case (fn)
            4'd0:    cond = 1;
            4'd1:    cond = lt || mZf;
            4'd2:    cond = lt;
            4'd3:    cond = mZf;
            4'd4:    cond = !mZf;
            4'd5:    cond = !lt;
            4'd6:    cond = !lt && !mZf;
            default: cond = 0;
        endcase
        if (ic == 4'h7 || (CMOV_EN && ic == 4'h2)) v.cnd = cond;
        case (ic)
            4'h6: begin
                v.aluA = b; v.aluB = a;
                if (fn == 4'd1) begin
                    wide = $signed({b[63], b}) - $signed({a[63], a});
                    v.aluCtrl = 2'b01;
                end else if (fn == 4'd2) begin
                    wide = {1'b0, b & a};
                    v.aluCtrl = 2'b10;
                end else if (fn == 4'd3) begin
                    wide = {1'b0, b ^ a};
                    v.aluCtrl = 2'b11;
                end else begin
                    wide = $signed({b[63], b}) + $signed({a[63], a});
                end
                if (fn <= 4'd3) begin
                    mZf = (wide[63:0] == 64'd0);
                    mSf = wide[63];
                    mOf = (fn <= 4'd1) ? (wide[64] != wide[63]) : 1'b0;
                end
            end
            4'h2: v.aluA = a;
            4'h3: v.aluA = c;
            4'h4, 4'h5: begin v.aluA = b; v.aluB = c; end
            4'h8, 4'hA: begin v.aluA = b; v.aluB = 64'hFFFF_FFFF_FFFF_FFF8; end
            4'h9, 4'hB: begin v.aluA = b; v.aluB = 64'd8; end
            default: ;
        endcase
        v.valE = v.aluA + v.aluB;
        if (ic == 4'h6 && fn == 4'd2) v.valE = a & b;
        if (ic == 4'h6 && fn == 4'd3) v.valE = a ^ b;
        if (ic == 4'h6 && fn == 4'd1) v.valE = b - a;
        v.zf = mZf; v.sf = mSf; v.of = mOf;
        return v;
    endfunction

    // One full transaction: handshake, EXEC-cycle ALU bus check, result
    // check on out_valid, optional stall with dropped in_valid pulses.
    task automatic applyStimulus(input vec_t v, input int stall, input bit pulse);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid  = 1'b1;
        bus.icode     = v.icode;
        bus.ifun      = v.ifun;
        bus.valA      = v.valA;
        bus.valB      = v.valB;
        bus.valC      = v.valC;
        bus.out_ready = (stall == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.valA     = ~v.valA;
        bus.valB     = ~v.valB;
        bus.valC     = ~v.valC;
        bus.ifun     = ~v.ifun;
        @(negedge clk);
        checkOutput("exec_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("exec_in_ready", {63'd0, bus.in_ready}, 64'd0);
        checkOutput("alu_ctrl", {62'd0, bus.alu_ctrl}, {62'd0, v.aluCtrl});
        checkOutput("alu_a", bus.alu_a, v.aluA);
        checkOutput("alu_b", bus.alu_b, v.aluB);
        @(negedge clk);
        checkOutput("out_valid", {63'd0, bus.out_valid}, 64'd1);
        checkOutput("valE", bus.valE, v.valE);
        checkOutput("cnd", {63'd0, bus.cnd}, {63'd0, v.cnd});
        checkOutput("cc_zf", {63'd0, bus.cc_zf}, {63'd0, v.zf});
        checkOutput("cc_sf", {63'd0, bus.cc_sf}, {63'd0, v.sf});
        checkOutput("cc_of", {63'd0, bus.cc_of}, {63'd0, v.of});
        for (int i = 0; i < stall; i++) begin
            if (pulse) begin
                bus.in_valid = (i % 2 == 0);
                bus.icode    = 4'h6;
                bus.ifun     = 4'h3;
                bus.valA     = 64'd5;
                bus.valB     = 64'd5;
            end
            @(negedge clk);
            checkOutput("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
            checkOutput("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
            checkOutput("hold_valE", bus.valE, v.valE);
            checkOutput("hold_cnd", {63'd0, bus.cnd}, {63'd0, v.cnd});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("post_in_ready", {63'd0, bus.in_ready}, 64'd1);
    endtask

    function automatic logic [63:0] pickOperand();
        logic [63:0] r;
        case ($urandom_range(0, 3))
            0:       r = 64'($urandom_range(0, 3));
            1:       r = {$urandom, $urandom};
            2:       r = 64'h8000_0000_0000_0000 | 64'($urandom_range(0, 3));
            default: r = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
        endcase
        return r;
    endfunction

    vec_t tbl[19];

    initial begin
        vec_t v;
        compared   = 0;
        mismatched = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.icode = '0; bus.ifun = '0;
        bus.valA = '0; bus.valB = '0; bus.valC = '0;

        // Directed table; CC expectations chain from one entry to the next.
        tbl[0]  = mk(4'h6, 4'h0, 64'd5, 64'd7, 64'd0, 64'd7, 64'd5, 2'b00, 64'd12, 1, 0, 0, 0);
        tbl[1]  = mk(4'h6, 4'h1, 64'd3, 64'd3, 64'd0, 64'd3, 64'd3, 2'b01, 64'd0, 1, 1, 0, 0);
        tbl[2]  = mk(4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 2'b00, 64'd0, 1, 1, 0, 0);
        tbl[3]  = mk(4'h6, 4'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0,
                     64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 2'b00,
                     64'h8000_0000_0000_0000, 1, 0, 1, 1);
        tbl[4]  = mk(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 2'b00, 64'd0, 0, 0, 1, 1);
        tbl[5]  = mk(4'hA, 4'h0, 64'h55, 64'h100, 64'h66, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 2'b00, 64'hF8, 1, 0, 1, 1);
        tbl[6]  = mk(4'hB, 4'h0, 64'h55, 64'h100, 64'h66, 64'h100, 64'd8, 2'b00, 64'h108, 1, 0, 1, 1);
        tbl[7]  = mk(4'h6, 4'h3, 64'hFF, 64'hFF, 64'd0, 64'hFF, 64'hFF, 2'b11, 64'd0, 1, 1, 0, 0);
        tbl[8]  = mk(4'h2, 4'h4, 64'h1234, 64'h99, 64'h77, 64'h1234, 64'd0, 2'b00, 64'h1234, !CMOV_EN, 1, 0, 0);
        tbl[9]  = mk(4'h6, 4'h7, 64'd1, 64'd2, 64'd0, 64'd2, 64'd1, 2'b00, 64'd3, 1, 1, 0, 0);
        tbl[10] = mk(4'h3, 4'h0, 64'd1, 64'd2, 64'hABC, 64'hABC, 64'd0, 2'b00, 64'hABC, 1, 1, 0, 0);
        tbl[11] = mk(4'h5, 4'h0, 64'd7, 64'h10, 64'h20, 64'h10, 64'h20, 2'b00, 64'h30, 1, 1, 0, 0);
        tbl[12] = mk(4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 2'b00, 64'd0, 0, 1, 0, 0);
        tbl[13] = mk(4'h6, 4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd0,
                     64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10,
                     64'h8000_0000_0000_0001, 1, 0, 1, 0);
        tbl[14] = mk(4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 2'b00, 64'd0, 0, 0, 1, 0);
        tbl[15] = mk(4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 2'b00, 64'd0, 0, 0, 1, 0);
        tbl[16] = mk(4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 2'b00, 64'd0, 1, 0, 1, 0);
        tbl[17] = mk(4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 2'b00, 64'd0, 1, 0, 1, 0);
        tbl[18] = mk(4'h0, 4'h0, 64'h9, 64'h9, 64'h9, 64'd0, 64'd0, 2'b00, 64'd0, 1, 0, 1, 0);

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        checkOutput("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("rst_valE", bus.valE, 64'd0);
        checkOutput("rst_cnd", {63'd0, bus.cnd}, 64'd0);
        checkOutput("rst_zf", {63'd0, bus.cc_zf}, 64'd1);
        checkOutput("rst_sf", {63'd0, bus.cc_sf}, 64'd0);
        checkOutput("rst_of", {63'd0, bus.cc_of}, 64'd0);
        checkOutput("rst_alu_a", bus.alu_a, 64'd0);
        checkOutput("rst_alu_ctrl", {62'd0, bus.alu_ctrl}, 64'd0);
        rst_n = 1'b1;

        // Directed vectors; pushq entry gets a 5-cycle stall with dropped pulses
        for (int i = 0; i < 19; i++) begin
            applyStimulus(tbl[i], (i == 5) ? 5 : 0, (i == 5));
        end

        // Reset asserted while in EXEC aborts the instruction
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.icode = 4'h6; bus.ifun = 4'h0;
        bus.valA = 64'd1; bus.valB = 64'd1; bus.valC = 64'd0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("exec_before_abort_alu_a", bus.alu_a, 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("abort_zf", {63'd0, bus.cc_zf}, 64'd1);
        checkOutput("abort_sf", {63'd0, bus.cc_sf}, 64'd0);
        checkOutput("abort_alu_a", bus.alu_a, 64'd0);
        checkOutput("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort_no_out_valid", {63'd0, bus.out_valid}, 64'd0);
        end
        checkOutput("abort_valE", bus.valE, 64'd0);

        // Randomized instructions against the model
        mZf = 1'b1; mSf = 1'b0; mOf = 1'b0;
        for (int n = 0; n < 150; n++) begin
            v = refModel(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         pickOperand(), pickOperand(), pickOperand());
            applyStimulus(v, $urandom_range(0, 2), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
